// File: rtl/vram_arbiter_pkg.sv
// Shared arbiter definitions: FSM encodings, port roles, and the watchdog fill word.
// Also holds the round-robin pointer advance helper.
package vera_pkg;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_t;

   localparam int PORT_HOST = 0;
   localparam int PORT_L0   = 1;
   localparam int PORT_L1   = 2;
   localparam int PORT_SPR  = 3;

   localparam logic [31:0] ARB_TIMEOUT_DATA = 32'hDEAD_BEEF;

   // Rotation only covers ports 1..nports-1; the host never enters the ring.
   function automatic int rr_next(input int idx, input int nports);
      return (idx >= nports - 1) ? 1 : idx + 1;
   endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// VRAM arbiter bus bundle: per-master strobe/ack request side plus the single slave side.
// master = renderer/host view, slave = VRAM controller view, arb = the arbiter itself.
interface vram_arbiter_if #(
   parameter int NPORTS = 4,
   parameter int ADDR_W = 18,
   parameter int DATA_W = 32
);
   logic [NPORTS-1:0]        req_strobe;
   logic [NPORTS-1:0]        req_write;
   logic [NPORTS*ADDR_W-1:0] req_addr;
   logic [NPORTS*DATA_W-1:0] req_wrdata;
   logic [NPORTS*4-1:0]      req_wrmask;
   logic [NPORTS-1:0]        req_ack;
   logic [DATA_W-1:0]        req_rddata;

   logic                     mem_strobe;
   logic                     mem_write;
   logic [ADDR_W-1:0]        mem_addr;
   logic [DATA_W-1:0]        mem_wrdata;
   logic [3:0]               mem_wrmask;
   logic [DATA_W-1:0]        mem_rddata;
   logic                     mem_ack;

   modport master (
      output req_strobe, req_write, req_addr, req_wrdata, req_wrmask,
      input  req_ack, req_rddata
   );

   modport slave (
      input  mem_strobe, mem_write, mem_addr, mem_wrdata, mem_wrmask,
      output mem_rddata, mem_ack
   );

   modport arb (
      input  req_strobe, req_write, req_addr, req_wrdata, req_wrmask,
      output req_ack, req_rddata,
      output mem_strobe, mem_write, mem_addr, mem_wrdata, mem_wrmask,
      input  mem_rddata, mem_ack
   );
endinterface

// File: rtl/vram_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping; zero latency.
// Pure function of its inputs, no state and no backpressure of its own.
module rr_pick #(
   parameter int N     = 3,
   parameter int PTR_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic             vld
);

   always_comb begin
      grant = '0;
      vld   = 1'b0;
      for (int j = 0; j < N; j++) begin
         if (!vld && req[j] && (j >= int'(ptr))) begin
            grant[j] = 1'b1;
            vld      = 1'b1;
         end
      end
      // Wrap-around pass picks up requests below the pointer.
      for (int j = 0; j < N; j++) begin
         if (!vld && req[j]) begin
            grant[j] = 1'b1;
            vld      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/vram_arbiter.sv
// VRAM bus arbiter: host-priority plus round-robin, one transaction in flight; grant 1 cycle after strobe, ack same cycle as mem_ack.
// Losers hold strobe until acked; optional watchdog under VRAM_ARB_WDOG_EN.
module vram_arbiter
   import vera_pkg::*;
#(
   parameter int NPORTS  = 4,
   parameter int ADDR_W  = 18,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          rst_n,
   vram_arbiter_if.arb   bus,
   input  logic          err_clr,
   output logic          err_timeout
);

   localparam int IDX_W = $clog2(NPORTS);
   localparam int NRR   = NPORTS - 1;

   arb_state_t        state, state_nx;
   logic [IDX_W-1:0]  grant_idx, rr_ptr, rr_off, win_idx;
   logic [NRR-1:0]    rr_grant;
   logic              rr_vld, any_req, done, wdog_hit;
   logic              sel_write;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wrdata;
   logic [3:0]        sel_wrmask;

   assign any_req = |bus.req_strobe;
   assign done    = (state == ARB_BUSY) && (bus.mem_ack || wdog_hit);
   assign rr_off  = rr_ptr - IDX_W'(1);

   rr_pick #(.N(NRR), .PTR_W(IDX_W)) u_rr_pick (
      .req   (bus.req_strobe[NPORTS-1:1]),
      .ptr   (rr_off),
      .grant (rr_grant),
      .vld   (rr_vld)
   );

   always_comb begin
      win_idx = IDX_W'(PORT_HOST);
      if (rr_vld) begin
         for (int j = 0; j < NRR; j++) begin
            if (rr_grant[j]) win_idx = IDX_W'(j + 1);
         end
      end
      if (bus.req_strobe[PORT_HOST]) win_idx = IDX_W'(PORT_HOST);
   end

   always_comb begin
      sel_write  = 1'b0;
      sel_addr   = '0;
      sel_wrdata = '0;
      sel_wrmask = '0;
      for (int p = 0; p < NPORTS; p++) begin
         if (win_idx == IDX_W'(p)) begin
            sel_write  = bus.req_write[p];
            sel_addr   = bus.req_addr[p*ADDR_W +: ADDR_W];
            sel_wrdata = bus.req_wrdata[p*DATA_W +: DATA_W];
            sel_wrmask = bus.req_wrmask[p*4 +: 4];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ARB_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ARB_IDLE: if (any_req) state_nx = ARB_BUSY;
         ARB_BUSY: if (done)    state_nx = ARB_IDLE;
         default:               state_nx = ARB_IDLE;
      endcase
   end

   always_comb begin
      bus.mem_strobe = 1'b0;
      bus.req_ack    = '0;
      bus.req_rddata = '0;
      if (state == ARB_BUSY) begin
         bus.mem_strobe = !done;
         if (done) begin
            for (int p = 0; p < NPORTS; p++) bus.req_ack[p] = (grant_idx == IDX_W'(p));
            bus.req_rddata = wdog_hit ? DATA_W'(ARB_TIMEOUT_DATA) : bus.mem_rddata;
         end
      end
   end

   // Slave-side fields are captured once at grant and held through BUSY.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_idx      <= '0;
         rr_ptr         <= IDX_W'(1);
         bus.mem_write  <= 1'b0;
         bus.mem_addr   <= '0;
         bus.mem_wrdata <= '0;
         bus.mem_wrmask <= '0;
      end else begin
         if (state == ARB_IDLE && any_req) begin
            grant_idx      <= win_idx;
            bus.mem_write  <= sel_write;
            bus.mem_addr   <= sel_addr;
            bus.mem_wrdata <= sel_wrdata;
            bus.mem_wrmask <= sel_wrmask;
         end
         if (done && grant_idx != IDX_W'(PORT_HOST)) begin
            rr_ptr <= IDX_W'(rr_next(int'(grant_idx), NPORTS));
         end
      end
   end

`ifdef VRAM_ARB_WDOG_EN
   logic [7:0] wdog_cnt;

   assign wdog_hit = (state == ARB_BUSY) && !bus.mem_ack && (wdog_cnt == 8'(TIMEOUT));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wdog_cnt    <= '0;
         err_timeout <= 1'b0;
      end else begin
         if (state == ARB_IDLE)  wdog_cnt <= '0;
         else if (!bus.mem_ack)  wdog_cnt <= wdog_cnt + 8'd1;
         if (wdog_hit)           err_timeout <= 1'b1;
         else if (err_clr)       err_timeout <= 1'b0;
      end
   end
`else
   logic unused_cfg;

   assign wdog_hit    = 1'b0;
   assign err_timeout = 1'b0;
   assign unused_cfg  = ^{err_clr, 8'(TIMEOUT)};
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed scoreboard bench for vram_arbiter: host priority, round-robin order, write hold, reset abort, watchdog.
module tb_vram_arbiter;
   import vera_pkg::*;

   localparam int NP = 4;
   localparam int AW = 18;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic err_clr = 1'b0;
   logic err_timeout;

   always #5 clk = ~clk;

   vram_arbiter_if #(.NPORTS(NP), .ADDR_W(AW), .DATA_W(DW)) bus ();

   vram_arbiter #(.NPORTS(NP), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .err_clr     (err_clr),
      .err_timeout (err_timeout)
   );

   typedef struct {
      int          port;
      logic        wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [3:0]  mask;
      logic [DW-1:0] rdata;
   } exp_t;

   exp_t          sb[$];
   logic          wr_of   [NP];
   logic [AW-1:0] addr_of [NP];
   logic [DW-1:0] wd_of   [NP];
   logic [3:0]    mask_of [NP];
   int checks = 0;
   int passed = 0;
   int fails  = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_req(input int p, input logic wr, input logic [AW-1:0] a,
                            input logic [DW-1:0] wd, input logic [3:0] m);
      wr_of[p] = wr; addr_of[p] = a; wd_of[p] = wd; mask_of[p] = m;
      bus.req_write[p]           = wr;
      bus.req_addr[p*AW +: AW]   = a;
      bus.req_wrdata[p*DW +: DW] = wd;
      bus.req_wrmask[p*4 +: 4]   = m;
      bus.req_strobe[p]          = 1'b1;
   endtask

   task automatic push(input int p, input logic [DW-1:0] rd);
      sb.push_back('{port: p, wr: wr_of[p], addr: addr_of[p], wdata: wd_of[p], mask: mask_of[p], rdata: rd});
   endtask

   // drop: 0 keep strobes, 1 drop granted port, 2 drop all ports
   task automatic serve(input int lat, input int drop);
      exp_t e;
      logic [NP-1:0] onehot;
      int waited = 0;
      do begin
         @(negedge clk); #1;
         waited++;
      end while (!bus.mem_strobe && waited < 40);
      chk("grant_latency", waited, 1);
      if (sb.size() == 0) begin
         $display("FAIL scoreboard underflow");
         $fatal(1);
      end
      e = sb.pop_front();
      for (int c = 0; c < lat; c++) begin
         if (c > 0) begin @(negedge clk); #1; end
         chk("mem_strobe_busy", bus.mem_strobe, 1);
         chk("mem_addr", bus.mem_addr, e.addr);
         chk("mem_write", bus.mem_write, e.wr);
         chk("mem_wrdata", bus.mem_wrdata, e.wdata);
         chk("mem_wrmask", bus.mem_wrmask, e.mask);
         chk("no_early_ack", bus.req_ack, 0);
      end
      @(negedge clk);
      bus.mem_ack = 1'b1; bus.mem_rddata = e.rdata;
      #1;
      onehot = '0; onehot[e.port] = 1'b1;
      chk("req_ack", bus.req_ack, onehot);
      chk("req_rddata", bus.req_rddata, e.rdata);
      chk("strobe_drop_on_ack", bus.mem_strobe, 0);
      @(negedge clk);
      bus.mem_ack = 1'b0; bus.mem_rddata = '0;
      if (drop == 1) bus.req_strobe[e.port] = 1'b0;
      if (drop == 2) bus.req_strobe = '0;
      #1;
      chk("ack_single_pulse", bus.req_ack, 0);
      chk("idle_gap", bus.mem_strobe, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      bus.req_strobe = '0; bus.mem_ack = 1'b0; bus.mem_rddata = '0; err_clr = 1'b0;
      #1;
      chk("rst_mem_strobe", bus.mem_strobe, 0);
      chk("rst_req_ack", bus.req_ack, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_mem_write", bus.mem_write, 0);
      chk("rst_mem_wrdata", bus.mem_wrdata, 0);
      chk("rst_mem_wrmask", bus.mem_wrmask, 0);
      chk("rst_err_timeout", err_timeout, 0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL global time limit reached");
      $fatal(1);
   end

   initial begin
      bus.req_strobe = '0; bus.req_write = '0; bus.req_addr = '0;
      bus.req_wrdata = '0; bus.req_wrmask = '0;
      bus.mem_ack = 1'b0; bus.mem_rddata = '0;

      // Single requester on port 2, slave answers after 3 strobe cycles.
      do_reset();
      @(negedge clk);
      drive_req(PORT_L1, 1'b0, 18'h00100, '0, 4'h0);
      push(PORT_L1, 32'h1122_3344);
      serve(3, 1);

      // Host beats the ring; ring starts at port 1.
      do_reset();
      @(negedge clk);
      drive_req(PORT_HOST, 1'b0, 18'h00010, '0, 4'h0);
      drive_req(PORT_L0,   1'b0, 18'h00020, '0, 4'h0);
      drive_req(PORT_SPR,  1'b0, 18'h00030, '0, 4'h0);
      push(PORT_HOST, 32'hA000_0000);
      push(PORT_L0,   32'hA000_0001);
      push(PORT_SPR,  32'hA000_0003);
      serve(1, 1);
      serve(2, 1);
      serve(1, 1);

      // Continuous requesters rotate without starvation.
      do_reset();
      @(negedge clk);
      drive_req(PORT_L0,  1'b0, 18'h01000, '0, 4'h0);
      drive_req(PORT_L1,  1'b0, 18'h02000, '0, 4'h0);
      drive_req(PORT_SPR, 1'b0, 18'h03000, '0, 4'h0);
      for (int r = 0; r < 2; r++) begin
         for (int p = 1; p < NP; p++) push(p, 32'hB000_0000 + 32'(r*16 + p));
      end
      for (int k = 0; k < 6; k++) serve(1 + (k % 2), (k == 5) ? 2 : 0);

      // Host write at top address: fields held stable for the whole transaction.
      do_reset();
      @(negedge clk);
      drive_req(PORT_HOST, 1'b1, 18'h3FFFF, 32'hAABB_CCDD, 4'b0101);
      push(PORT_HOST, 32'h0);
      serve(4, 1);

      // Reset while BUSY aborts silently and restores the ring pointer.
      do_reset();
      @(negedge clk);
      drive_req(PORT_L0, 1'b0, 18'h00444, '0, 4'h0);
      push(PORT_L0, 32'hC000_0001);
      serve(1, 1);
      @(negedge clk);
      drive_req(PORT_L1, 1'b0, 18'h00555, '0, 4'h0);
      @(negedge clk); #1;
      chk("abort_busy_strobe", bus.mem_strobe, 1);
      chk("abort_busy_addr", bus.mem_addr, 18'h00555);
      @(negedge clk);
      rst_n = 1'b0; bus.mem_ack = 1'b1; bus.mem_rddata = 32'h5555_5555;
      #1;
      chk("abort_strobe_low", bus.mem_strobe, 0);
      chk("abort_no_ack", bus.req_ack, 0);
      @(negedge clk);
      rst_n = 1'b1; bus.mem_ack = 1'b0; bus.mem_rddata = '0;
      drive_req(PORT_L0, 1'b0, 18'h00666, '0, 4'h0);
      #1;
      chk("abort_release_no_ack", bus.req_ack, 0);
      push(PORT_L0, 32'hC000_0002);
      push(PORT_L1, 32'hC000_0003);
      serve(1, 1);
      serve(1, 1);

`ifdef VRAM_ARB_WDOG_EN
      begin
         int n = 0;
         do_reset();
         @(negedge clk);
         drive_req(PORT_SPR, 1'b0, 18'h00777, '0, 4'h0);
         @(negedge clk); #1;
         while (bus.mem_strobe && n < 100) begin
            n++;
            @(negedge clk); #1;
         end
         chk("wdog_busy_cycles", n, 16);
         chk("wdog_ack", bus.req_ack, 4'b1000);
         chk("wdog_rddata", bus.req_rddata, ARB_TIMEOUT_DATA);
         @(negedge clk);
         bus.req_strobe = '0;
         #1;
         chk("wdog_err_set", err_timeout, 1);
         chk("wdog_ack_single", bus.req_ack, 0);
         @(negedge clk);
         bus.mem_ack = 1'b1; bus.mem_rddata = 32'h1234_5678;
         #1;
         chk("late_ack_ignored", bus.req_ack, 0);
         chk("late_ack_no_strobe", bus.mem_strobe, 0);
         @(negedge clk);
         bus.mem_ack = 1'b0; err_clr = 1'b1;
         #1;
         chk("err_sticky", err_timeout, 1);
         @(negedge clk);
         err_clr = 1'b0;
         #1;
         chk("err_cleared", err_timeout, 0);
      end
`endif

      chk("scoreboard_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
